// File: rtl/dmm_access_ctrl.sv
// Data-memory access controller: drives one bus transaction per memory-stage
// instruction. Define DMM_LOAD_ALIGN_EN to lane-select and extend load data here.
module dmm_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   input  logic        mem_valid,
   input  logic        mem_cancel,
   input  logic [2:0]  mem_lw_sw_type,
   input  logic        mem_lb_unsigned,
   input  logic [31:0] mem_dmm_addr,
   input  logic [3:0]  mem_dmm_byte_enable,
   input  logic [31:0] mem_dmm_wt_val,
   output logic        complete,
   output logic [31:0] dmm_load_val,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        cancel_q, cancel_d;
   logic [31:0] load_q, load_d;
   logic        need;
   logic        is_store;
   logic [31:0] rd_val;

   function automatic logic [1:0] size_of(input logic [2:0] t);
      case (t)
         3'd1, 3'd5:       size_of = 2'd0;
         3'd2, 3'd3, 3'd6: size_of = 2'd1;
         default:          size_of = 2'd2;
      endcase
   endfunction

`ifdef DMM_LOAD_ALIGN_EN
   logic [2:0] type_q, type_d;
   logic       uns_q, uns_d;

   function automatic logic [31:0] align_load(input logic [2:0]  t,
                                              input logic        u,
                                              input logic [1:0]  a,
                                              input logic [31:0] r);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = r[7:0];
         2'd1:    b = r[15:8];
         2'd2:    b = r[23:16];
         default: b = r[31:24];
      endcase
      h = a[1] ? r[31:16] : r[15:0];
      case (t)
         3'd1:    align_load = u ? {24'd0, b} : {{24{b[7]}}, b};
         3'd2:    align_load = {{16{h[15]}}, h};
         3'd3:    align_load = {16'd0, h};
         default: align_load = r;
      endcase
   endfunction

   assign rd_val = align_load(type_q, uns_q, addr_q[1:0], data_rdata);
`else
   assign rd_val = data_rdata;
`endif

   assign need     = mem_valid && (mem_lw_sw_type != 3'd0) && !mem_cancel;
   assign is_store = (mem_lw_sw_type >= 3'd5);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      size_d   = size_q;
      cancel_d = cancel_q;
      load_d   = load_q;
`ifdef DMM_LOAD_ALIGN_EN
      type_d   = type_q;
      uns_d    = uns_q;
`endif
      complete = 1'b0;
      data_req = 1'b0;
      case (state_q)
         IDLE: begin
            complete = !need;
            if (need) begin
               state_d  = REQ;
               addr_d   = (mem_lw_sw_type == 3'd4 || mem_lw_sw_type == 3'd7)
                          ? {mem_dmm_addr[31:2], 2'b00} : mem_dmm_addr;
               wr_d     = is_store;
               wstrb_d  = is_store ? mem_dmm_byte_enable : '0;
               wdata_d  = mem_dmm_wt_val;
               size_d   = size_of(mem_lw_sw_type);
               cancel_d = 1'b0;
`ifdef DMM_LOAD_ALIGN_EN
               type_d   = mem_lw_sw_type;
               uns_d    = mem_lb_unsigned;
`endif
            end
         end
         REQ: begin
            data_req = 1'b1;
            if (data_addr_ok) begin
               if (data_data_ok) begin
                  state_d = mem_cancel ? IDLE : DONE;
                  if (!mem_cancel) load_d = rd_val;
               end else begin
                  state_d  = WAIT;
                  cancel_d = mem_cancel;
               end
            end else if (mem_cancel) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            // an accepted request must drain its response even when cancelled
            cancel_d = cancel_q | mem_cancel;
            if (data_data_ok) begin
               if (cancel_q || mem_cancel) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  load_d  = rd_val;
               end
            end
         end
         DONE: begin
            complete = 1'b1;
            if (ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wstrb_q  <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         size_q   <= '0;
         cancel_q <= 1'b0;
         load_q   <= '0;
`ifdef DMM_LOAD_ALIGN_EN
         type_q   <= '0;
         uns_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         cancel_q <= cancel_d;
         load_q   <= load_d;
`ifdef DMM_LOAD_ALIGN_EN
         type_q   <= type_d;
         uns_q    <= uns_d;
`endif
      end
   end

`ifndef DMM_LOAD_ALIGN_EN
   logic unused_uns;
   assign unused_uns = mem_lb_unsigned;
`endif

   assign dmm_load_val = load_q;
   assign data_wr      = wr_q;
   assign data_size    = size_q;
   assign data_addr    = addr_q;
   assign data_wstrb   = wstrb_q;
   assign data_wdata   = wdata_q;

endmodule
